// File: rtl/truth_table_scanner.sv
// Purpose: drives every input vector into a small combinational block, samples its output, builds and checks the truth table.
// Latency: SETTLE+1 cycles per vector; done pulses 2^IN_W*(SETTLE+1)+1 cycles after start is accepted.
// Backpressure: none; start is taken only in IDLE and ignored while busy or done.
module truth_table_scanner #(
    parameter int IN_W   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [(1<<IN_W)-1:0]   expected,
    output logic [IN_W-1:0]        dut_in,
    input  logic                   dut_out,
    output logic                   busy,
    output logic                   done,
    output logic [(1<<IN_W)-1:0]   table_out,
    output logic [IN_W:0]          ones_cnt,
    output logic                   mismatch,
    output logic [IN_W-1:0]        first_err
);

    localparam int TW = 1 << IN_W;
    // Settle counter only needs to reach SETTLE-1.
    localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
    localparam logic [CW-1:0]   CNT_LAST = CW'(SETTLE - 1);
    localparam logic [IN_W-1:0] LAST_VEC = {IN_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CW-1:0]      r_cnt;
    logic [IN_W-1:0]    r_dut_in;
    logic [TW-1:0]      r_exp;
    logic [TW-1:0]      r_table;
    logic [IN_W:0]      r_ones;
    logic               r_mismatch;
    logic [IN_W-1:0]    r_first_err;
    logic               w_busy;
    logic               w_done;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state: hold each vector SETTLE cycles, sample once, stop after the all-ones vector.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (start) w_next = S_WAIT;
            S_WAIT:   if (r_cnt == CNT_LAST) w_next = S_SAMPLE;
            S_SAMPLE: w_next = (r_dut_in == LAST_VEC) ? S_DONE : S_WAIT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Status outputs decode directly from state.
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        unique case (r_state)
            S_WAIT, S_SAMPLE: w_busy = 1'b1;
            S_DONE:           w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Datapath: latch golden table at start, capture one table bit per SAMPLE, track first error.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_dut_in    <= '0;
            r_exp       <= '0;
            r_table     <= '0;
            r_ones      <= '0;
            r_mismatch  <= 1'b0;
            r_first_err <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_exp       <= expected;
                        r_table     <= '0;
                        r_ones      <= '0;
                        r_mismatch  <= 1'b0;
                        r_first_err <= '0;
                        r_dut_in    <= '0;
                        r_cnt       <= '0;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                end
                S_SAMPLE: begin
                    r_table[r_dut_in] <= dut_out;
                    r_ones            <= r_ones + {{IN_W{1'b0}}, dut_out};
                    if ((dut_out != r_exp[r_dut_in]) && !r_mismatch) begin
                        r_mismatch  <= 1'b1;
                        r_first_err <= r_dut_in;
                    end
                    // The last vector is left in place; DONE returns dut_in to zero.
                    if (r_dut_in != LAST_VEC) begin
                        r_dut_in <= r_dut_in + 1'b1;
                    end
                    r_cnt <= '0;
                end
                S_DONE: begin
                    r_dut_in <= '0;
                end
                default: begin
                    r_dut_in <= '0;
                end
            endcase
        end
    end

    assign dut_in    = r_dut_in;
    assign busy      = w_busy;
    assign done      = w_done;
    assign table_out = r_table;
    assign ones_cnt  = r_ones;
    assign mismatch  = r_mismatch;
    assign first_err = r_first_err;

endmodule

// File: tb/tb_truth_table_scanner.sv
// Bench for truth_table_scanner: a 3-input instance against majority-style models
// and a 2-input, SETTLE=3 instance against a two-cycle-delayed XOR.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a;
    logic [7:0] exp_a;
    logic [2:0] dutin_a;
    logic       dout_a;
    logic       busy_a, done_a, mm_a;
    logic [7:0] table_a;
    logic [3:0] ones_a;
    logic [2:0] fe_a;

    logic       start_b;
    logic [3:0] exp_b;
    logic [1:0] dutin_b;
    logic       dout_b;
    logic       busy_b, done_b, mm_b;
    logic [3:0] table_b;
    logic [2:0] ones_b;
    logic [1:0] fe_b;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;
    int mode_a = 0;

    typedef struct {
        logic [7:0] tbl;
        logic [3:0] ones;
        logic       mm;
        logic [2:0] fe;
    } res_t;
    res_t sb[$];

    function automatic logic model_a(input int m, input logic [2:0] v);
        logic maj;
        maj = (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
        case (m)
            0:       return maj;
            1:       return (v == 3'd5) ? 1'b0 : maj;
            default: return 1'b1;
        endcase
    endfunction

    assign dout_a = model_a(mode_a, dutin_a);

    // Block under test for instance B: XOR whose output lags its input by two clocks.
    logic [1:0] d1 = 2'b00;
    logic [1:0] d2 = 2'b00;
    always @(posedge clk) begin
        d1 <= dutin_b;
        d2 <= d1;
    end
    assign dout_b = d2[0] ^ d2[1];

    truth_table_scanner #(.IN_W(3), .SETTLE(1)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .expected(exp_a),
        .dut_in(dutin_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
        .table_out(table_a), .ones_cnt(ones_a), .mismatch(mm_a), .first_err(fe_a)
    );

    truth_table_scanner #(.IN_W(2), .SETTLE(3)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .expected(exp_b),
        .dut_in(dutin_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
        .table_out(table_b), .ones_cnt(ones_b), .mismatch(mm_b), .first_err(fe_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input logic [7:0] expv, input int mode);
        res_t r;
        logic b;
        r.tbl = '0; r.ones = '0; r.mm = 1'b0; r.fe = '0;
        for (int i = 0; i < 8; i++) begin
            b = model_a(mode, 3'(i));
            r.tbl[i] = b;
            r.ones = r.ones + {3'b000, b};
            if ((b != expv[i]) && !r.mm) begin
                r.mm = 1'b1;
                r.fe = 3'(i);
            end
        end
        sb.push_back(r);
    endtask

    // One full scan on instance A; rp1/rp2 are cycles in which start is re-driven (0 = none).
    task automatic run_a(input string nm, input logic [7:0] expv, input int mode,
                         input int rp1, input int rp2);
        int done_cyc;
        int nd;
        int nb;
        res_t r;
        logic [7:0] t0;
        mode_a = mode;
        exp_a  = expv;
        push_model(expv, mode);
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        exp_a   = ~expv;
        done_cyc = -1; nd = 0; nb = 0;
        for (int c = 1; c <= 18; c++) begin
            if (c == 1) begin
                chk({nm, "_clr_tbl"},  table_a, 0);
                chk({nm, "_clr_ones"}, ones_a, 0);
                chk({nm, "_clr_mm"},   mm_a, 0);
                chk({nm, "_clr_fe"},   fe_a, 0);
                chk({nm, "_clr_in"},   dutin_a, 0);
            end
            if (c == 3) begin
                t0 = '0;
                t0[0] = model_a(mode, 3'd0);
                chk({nm, "_mid_tbl"}, table_a, t0);
                chk({nm, "_mid_in"},  dutin_a, 1);
            end
            if (busy_a) nb++;
            if (done_a) begin
                nd++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    chk({nm, "_sb_depth"}, sb.size(), 1);
                    if (sb.size() > 0) begin
                        r = sb.pop_front();
                        chk({nm, "_tbl"},  table_a, r.tbl);
                        chk({nm, "_ones"}, ones_a, r.ones);
                        chk({nm, "_mm"},   mm_a, r.mm);
                        chk({nm, "_fe"},   fe_a, r.fe);
                        chk({nm, "_busy_in_done"}, busy_a, 0);
                    end
                end
            end
            start_a = (c == rp1) || (c == rp2);
            tick;
        end
        start_a = 1'b0;
        chk({nm, "_done_cyc"},  done_cyc, 17);
        chk({nm, "_busy_cyc"},  nb, 16);
        chk({nm, "_done_cnt"},  nd, 1);
        chk({nm, "_idle_busy"}, busy_a, 0);
        chk({nm, "_idle_in"},   dutin_a, 0);
        chk({nm, "_hold_tbl"},  table_a, model_a(mode, 3'd7) ? table_a | 8'h80 : table_a & 8'h7F);
    endtask

    initial begin
        int nd;
        int nb;
        int done_cyc;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; exp_a = 8'h00; exp_b = 4'h0;
        tick;
        tick;
        rst = 1'b0;
        tick;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_tbl",  table_a, 0);
        chk("rst_ones", ones_a, 0);
        chk("rst_mm",   mm_a, 0);
        chk("rst_in",   dutin_a, 0);

        run_a("maj",    8'hE8, 0, 0, 0);
        run_a("maj5",   8'hE8, 1, 0, 0);
        run_a("const1", 8'h00, 2, 5, 17);
        run_a("restart", 8'hE8, 0, 0, 0);

        // Abort mid-scan with reset: rst held during cycle 9.
        mode_a = 0; exp_a = 8'hE8; start_a = 1'b1;
        tick;
        start_a = 1'b0;
        for (int c = 1; c < 9; c++) tick;
        chk("pre_rst_busy", busy_a, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", busy_a, 0);
        chk("abort_done", done_a, 0);
        chk("abort_tbl",  table_a, 0);
        chk("abort_ones", ones_a, 0);
        chk("abort_mm",   mm_a, 0);
        chk("abort_fe",   fe_a, 0);
        chk("abort_in",   dutin_a, 0);
        nd = 0;
        for (int c = 0; c < 12; c++) begin
            if (done_a || busy_a) nd++;
            tick;
        end
        chk("abort_quiet", nd, 0);
        run_a("after_rst", 8'hE8, 1, 0, 0);

        // Instance B: IN_W=2, SETTLE=3, delayed XOR block.
        exp_b = 4'h6; start_b = 1'b1;
        tick;
        start_b = 1'b0;
        exp_b = 4'h0;
        nd = 0; nb = 0; done_cyc = -1;
        for (int c = 1; c <= 18; c++) begin
            if (c <= 16) chk("b_dut_in", dutin_b, (c - 1) / 4);
            if (busy_b) nb++;
            if (done_b) begin
                nd++;
                if (done_cyc < 0) done_cyc = c;
            end
            tick;
        end
        chk("b_done_cyc", done_cyc, 17);
        chk("b_busy_cyc", nb, 16);
        chk("b_done_cnt", nd, 1);
        chk("b_tbl",  table_b, 4'h6);
        chk("b_ones", ones_b, 2);
        chk("b_mm",   mm_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
